// File: rtl/uart_pkg.sv
// uart_pkg: shared types, widths and baud helper for the UART/AXI-Stream bridge.
package uart_pkg;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO buffering received UART data.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_pop,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign o_empty = cnt_q == '0;
    assign o_full  = cnt_q == CW'(DEPTH);
    assign o_count = cnt_q;
    assign o_data  = mem_q[rd_q];

    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    always_comb begin
        do_pop  = i_pop && !o_empty;
        do_push = i_push && (!o_full || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = i_data;
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_axis_bridge.sv
// uart_axis_bridge: 8N1 UART receiver/transmitter bridged to AXI-Stream byte ports,
// with a FWFT FIFO absorbing downstream back-pressure on the receive side.
module uart_axis_bridge
    import uart_pkg::*;
#(
    parameter int CLK_HZ        = 27_000_000,
    parameter int BAUD          = 115_200,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_uart_rx,
    output logic              o_uart_tx,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic              o_rx_frame_err,
    output logic              o_rx_overrun,
    output logic              o_tx_busy
);
    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);

    logic [1:0]                    rx_sync_q;
    rx_state_e                     rx_state_q, rx_state_d;
    logic [CW-1:0]                 rx_cnt_q, rx_cnt_d;
    logic [2:0]                    rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0]             rx_shift_q, rx_shift_d;
    logic                          frame_err_q, frame_err_d;
    logic                          overrun_q, overrun_d;
    logic                          rx_line, rx_push, rx_pop, fifo_full, fifo_empty;
    logic [$clog2(RX_FIFO_DEPTH):0] unused_count;

    tx_state_e                     tx_state_q, tx_state_d;
    logic [CW-1:0]                 tx_cnt_q, tx_cnt_d;
    logic [2:0]                    tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0]             tx_shift_q, tx_shift_d;
    logic                          tx_q, tx_d;
    logic                          tx_rdy_q, tx_rdy_d;

    assign rx_line        = rx_sync_q[1];
    assign m_axis_tvalid  = !fifo_empty;
    assign rx_pop         = m_axis_tvalid && m_axis_tready;
    assign o_rx_frame_err = frame_err_q;
    assign o_rx_overrun   = overrun_q;
    assign o_uart_tx      = tx_q;
    assign s_axis_tready  = tx_rdy_q;
    assign o_tx_busy      = tx_state_q != TX_IDLE;

    uart_rx_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (rx_push),
        .i_data  (rx_shift_q),
        .i_pop   (rx_pop),
        .o_data  (m_axis_tdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (unused_count)
    );

    // START sampling at half a bit both rejects glitches and centres later samples.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + CW'(1);
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_line) begin
                    rx_state_d = RX_START;
                    rx_bit_d   = '0;
                end
            end
            RX_START: if (rx_cnt_q == HALF_END) begin
                rx_cnt_d   = '0;
                rx_state_d = rx_line ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_line, rx_shift_q[DATA_W-1:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d    = '0;
                rx_push     = rx_line;
                frame_err_d = !rx_line;
                rx_state_d  = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
        overrun_d = rx_push && fifo_full && !rx_pop;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                if (s_axis_tvalid && tx_rdy_q) begin
                    tx_state_d = TX_START;
                    tx_shift_d = s_axis_tdata;
                    tx_d       = 1'b0;
                end
            end
            TX_START: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_d       = tx_shift_q[0];
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d   = '0;
                tx_bit_d   = tx_bit_q + 3'd1;
                tx_shift_d = tx_shift_q >> 1;
                tx_d       = (tx_bit_q == 3'd7) ? 1'b1 : tx_shift_q[1];
                if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            end
            TX_STOP: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d   = '0;
                tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        tx_rdy_d = tx_state_d == TX_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_sync_q   <= 2'b11;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            tx_rdy_q    <= 1'b0;
        end else begin
            rx_sync_q   <= {rx_sync_q[0], i_uart_rx};
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            tx_rdy_q    <= tx_rdy_d;
        end
    end
endmodule

// File: tb/tb_uart_axis_bridge.sv
// tb_uart_axis_bridge: scoreboard bench for the UART/AXI-Stream bridge at 10 clocks per bit.
module tb_uart_axis_bridge;
    localparam int CPB = 10;

    logic       clk = 1'b0, rst_n = 1'b1, uart_rx = 1'b1, m_tready = 1'b0, s_tvalid = 1'b0;
    logic [7:0] s_tdata = '0;
    logic       uart_tx, m_tvalid, s_tready, ferr, ovr, busy;
    logic [7:0] m_tdata;

    always #5 clk = ~clk;

    uart_axis_bridge #(.CLK_HZ(1_000_000), .BAUD(100_000), .RX_FIFO_DEPTH(16)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_uart_rx      (uart_rx),
        .o_uart_tx      (uart_tx),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .o_rx_frame_err (ferr),
        .o_rx_overrun   (ovr),
        .o_tx_busy      (busy)
    );

    int         n_tests = 0, n_fail = 0;
    int         beats = 0, ferr_cycles = 0, ovr_cycles = 0, cyc = 0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];
    int         fall_cyc[$];
    logic       stall_q = 1'b0;
    logic [7:0] stall_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rx_bit(input logic v);
        uart_rx = v;
        repeat (CPB) tick();
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input logic expect_push);
        if (expect_push) rx_exp_q.push_back(b);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop);
        uart_rx = 1'b1;
        repeat (2) tick();
    endtask

    task automatic tx_send(input logic [7:0] b);
        int n;
        s_tdata  = b;
        s_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_tready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("tx_accepted", s_tready, 1);
        tick();
        tx_exp_q.push_back(b);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ferr) ferr_cycles++;
            if (ovr) ovr_cycles++;
            if (stall_q && m_tvalid) check("rx_hold", m_tdata, stall_data);
            if (m_tvalid && m_tready) begin
                beats++;
                check("rx_sb_nonempty", rx_exp_q.size() != 0, 1);
                if (rx_exp_q.size() != 0) check("rx_data", m_tdata, rx_exp_q.pop_front());
            end
            stall_q    = m_tvalid && !m_tready;
            stall_data = m_tdata;
        end else stall_q = 1'b0;
    end

    // Frame checker: every cycle of a frame is compared against the expected bit.
    always @(negedge clk) begin
        if (rst_n && uart_tx === 1'b0) begin
            logic [9:0] frame;
            logic [7:0] b;
            int         bad;
            bit         aborted;
            fall_cyc.push_back(cyc);
            check("tx_sb_nonempty", tx_exp_q.size() != 0, 1);
            b       = (tx_exp_q.size() != 0) ? tx_exp_q.pop_front() : 8'h00;
            frame   = {1'b1, b, 1'b0};
            bad     = 0;
            aborted = 0;
            for (int i = 0; i < 10 * CPB; i++) begin
                if (!rst_n) begin
                    aborted = 1;
                    break;
                end
                if (uart_tx !== frame[i / CPB] || s_tready !== 1'b0 || busy !== 1'b1) bad++;
                @(negedge clk);
            end
            if (!aborted) check("tx_frame", bad, 0);
        end
    end

    initial begin
        int b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_tx", uart_tx, 1);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tready", s_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", ferr, 0);
        check("rst_ovr", ovr, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_ready_before_edge", s_tready, 0);
        @(negedge clk);
        check("rst_rel_ready_one_edge", s_tready, 1);

        tick();
        m_tready = 1'b1;
        send_rx(8'hA5, 1'b1, 1'b1);
        repeat (10) tick();
        check("t1_beats", beats, 1);
        check("t1_sb_drained", rx_exp_q.size(), 0);
        check("t1_ferr", ferr_cycles, 0);
        check("t1_ovr", ovr_cycles, 0);

        b0 = beats;
        uart_rx = 1'b0;
        repeat (3) tick();
        uart_rx = 1'b1;
        repeat (150) tick();
        check("t2_no_push", beats, b0);
        check("t2_no_ferr", ferr_cycles, 0);
        check("t2_tvalid", m_tvalid, 0);

        send_rx(8'h3C, 1'b0, 1'b0);
        repeat (20) tick();
        check("t3_ferr_one_cycle", ferr_cycles, 1);
        check("t3_no_push", beats, b0);
        check("t3_tvalid", m_tvalid, 0);

        m_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send_rx(8'(i), 1'b1, i < 16);
            if (i == 15) check("t4_no_ovr_before_0x10", ovr_cycles, 0);
        end
        repeat (10) tick();
        check("t4_ovr_once", ovr_cycles, 1);
        check("t4_tvalid_full", m_tvalid, 1);
        check("t4_held", rx_exp_q.size(), 16);
        m_tready = 1'b1;
        repeat (30) tick();
        check("t4_drained", rx_exp_q.size(), 0);
        check("t4_beats", beats, b0 + 16);
        check("t4_tvalid_drop", m_tvalid, 0);
        check("t4_ovr_total", ovr_cycles, 1);

        tx_send(8'h55);
        tx_send(8'h0F);
        s_tvalid = 1'b0;
        repeat (250) tick();
        check("t5_sb_drained", tx_exp_q.size(), 0);
        check("t5_frames", fall_cyc.size(), 2);
        if (fall_cyc.size() == 2) check("t5_gap_le1", (fall_cyc[1] - fall_cyc[0]) <= 10 * CPB + 1, 1);
        check("t5_idle_ready", s_tready, 1);
        check("t5_idle_busy", busy, 0);

        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) send_rx(8'h80 + 8'(i), 1'b1, 1'b0);
        repeat (5) tick();
        check("t6_queued", m_tvalid, 1);
        tx_send(8'hC3);
        s_tvalid = 1'b0;
        repeat (30) tick();
        check("t6_busy_mid", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_async_tx", uart_tx, 1);
        check("t6_async_tvalid", m_tvalid, 0);
        check("t6_async_tdata", m_tdata, 0);
        check("t6_async_ready", s_tready, 0);
        check("t6_async_busy", busy, 0);
        tx_exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("t6_rel_ready_before_edge", s_tready, 0);
        @(posedge clk);
        #1;
        check("t6_rel_ready_one_edge", s_tready, 1);
        b0 = beats;
        m_tready = 1'b1;
        repeat (20) tick();
        check("t6_fifo_flushed", beats, b0);
        check("t6_line_idle", uart_tx, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
